uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one `uart_tx` transmitter between NUM_REQ byte producers. It sits between the producers and `uart_tx`, where it drives `tx_start`/`tx_data` and watches `tx_busy`. Requesters are served round-robin, one byte per grant. A watchdog flags frames that `uart_tx` never accepts.

## Interface

Parameters:
- NUM_REQ, 4: number of requesters, legal range 2..16.
- DATA_W, 8: byte width; must match `uart_tx`.
- START_TIMEOUT, 4096: max clk cycles that `tx_start` is held without `tx_busy` rising.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  requester i has a byte pending; held until `req_ack[i]`.
- req_data  in  NUM_REQ*DATA_W  byte i at `[i*DATA_W +: DATA_W]`; stable while `req[i]` is high.
- req_lock  in  NUM_REQ  keep grant for the next byte (present only with UART_TX_ARB_LOCK_EN).
- req_ack  out  NUM_REQ  one-cycle pulse: byte i captured.
- tx_start  out  1  to `uart_tx`.
- tx_data  out  DATA_W  to `uart_tx`, registered.
- tx_busy  in  1  from `uart_tx`.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last winner.
- arb_busy  out  1  high in START or SEND.
- tx_error  out  1  one-cycle pulse on start timeout.

## Operation

- FSM states: IDLE, START, SEND.
- **IDLE**
  - Arbitrates only when `tx_busy` is 0 and `req` is nonzero.
  - Winner is the first set `req` bit searching upward from `last_grant+1`, with wrap-around.
  - On a win, in the same edge: latch `req_data[winner]` into `tx_data`, pulse `req_ack[winner]`, set `grant_id`, move to START.
- **START**
  - `tx_start` is 1.
  - `tx_busy` == 1: go to SEND, `tx_start` goes to 0, clear timer.
  - Timer reaches START_TIMEOUT-1 without `tx_busy`: pulse `tx_error`, `tx_start` goes to 0, go to IDLE. The byte is dropped, because it was already acked.
- **SEND**
  - Wait for `tx_busy` == 0, then go to IDLE.
  - On that exit, `last_grant <= grant_id`.
- Timer width is $clog2(START_TIMEOUT+1). It counts only in START and saturates.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `last_grant` = NUM_REQ-1, so requester 0 wins first after reset.
- Boundary conditions:
  - `tx_busy` high in IDLE (foreign or leftover frame): no arbitration and no ack until it drops.
  - Winner drops `req` during START or SEND: no effect, since the data is already latched.
  - A requester sees a new `req` in the cycle after its ack: it is eligible again only after the others have had their turn.
  - All `req` are 0: stay in IDLE and hold `tx_data`.
  - Reset asserted mid-frame: `tx_start` and `arb_busy` drop immediately (async), `last_grant` reinits, and no ack is emitted. `uart_tx` is reset by the same `rst_n`.

## Timing

- Latency from `req[i]` rising (FSM in IDLE, `tx_busy` 0) to `req_ack[i]`, `tx_start`=1 and `tx_data` valid: 1 clk edge.
- `tx_start` stays high from entry into START until the edge after `tx_busy` is first sampled high. This covers the wait for the next baud tick.
- Minimum gap between the fall of `tx_busy` and the next `tx_start`: 2 edges (SEND→IDLE, then IDLE→START).
- `req_ack` is exactly one cycle long. At most one `req_ack` bit is high in any cycle.

## Configuration

- Macro: UART_TX_ARB_LOCK_EN.
- **Defined**
  - The `req_lock` port exists.
  - On the SEND→IDLE exit, if `req_lock[grant_id]` is 1, the next IDLE arbitration grants `grant_id` again provided `req[grant_id]` is 1.
  - If `req[grant_id]` is 0, arbitration falls back to round-robin.
  - While lock is in effect, `last_grant` is not advanced.
- **Undefined**
  - The port is absent.
  - Strict round-robin, one byte per grant.

## Structure

- Shared package `uart_pkg`: FSM state encoding (IDLE=0, START=1, SEND=2) and the default DATA_W.
- One sub-module, `rr_picker`:
  - Combinational.
  - Inputs: `req` vector and `last_grant`.
  - Outputs: winner index and a valid bit.
  - Reusable by other shared-resource blocks.

## Test plan

- Single requester: reset; `req`=4'b0001, byte 0x55 → `req_ack[0]` one cycle later, `tx_start`=1 until `tx_busy`; `tx_data`=0x55; looped-back serial line decodes 0x55.
- All four requesting: `req`=4'b1111, bytes 0xA0..0xA3 → serial order A0, A1, A2, A3, then A0 again if re-requested; exactly one ack per frame.
- Wrap-around: `last_grant`=3, `req`=4'b1001 → requester 0 wins, then requester 3.
- Timeout: START_TIMEOUT=16, `tx_busy` tied 0 → `tx_error` pulse on the 16th START cycle, `tx_start` returns to 0, FSM back in IDLE, next request served.
- Reset mid-frame: `rst_n`=0 during SEND → all outputs 0 within the reset assertion; after release, requester 0 has priority.
- Lock (macro defined): `req_lock[2]`=1, `req`=4'b0110, three bytes from requester 2 → all three sent before requester 1. Macro undefined → requesters 1 and 2 alternate.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding and defaults for the uart_tx arbiter
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search starting after last_grant
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_grant_i,
  output logic [$clog2(N)-1:0] winner_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);

  // Scan offsets from farthest to nearest so the nearest set bit after last_grant wins
  always_comb begin
    int idx;
    idx      = 0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = N; k >= 1; k--) begin
      idx = int'(last_grant_i) + k;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) begin
        winner_o = IW'(idx);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx; optional grant lock via UART_TX_ARB_LOCK_EN
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int START_TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       tx_error
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(START_TIMEOUT + 1);

  arb_state_e         state_q;
  logic [IW-1:0]      last_grant_q;
  logic [IW-1:0]      grant_id_q;
  logic [NUM_REQ-1:0] req_ack_q;
  logic               tx_start_q;
  logic [DATA_W-1:0]  tx_data_q;
  logic               arb_busy_q;
  logic               tx_error_q;
  logic [TW-1:0]      timer_q;
  logic [TW-1:0]      timer_d;
  logic [IW-1:0]      rr_id;
  logic               rr_vld;
  logic [IW-1:0]      pick_id;
  logic               pick_vld;
  logic               timeout;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .winner_o     (rr_id),
    .valid_o      (rr_vld)
  );

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_q;

  // A held lock re-grants the previous winner while it still has a byte pending
  always_comb begin
    pick_id  = rr_id;
    pick_vld = rr_vld;
    if (lock_q && req[grant_id_q]) begin
      pick_id  = grant_id_q;
      pick_vld = 1'b1;
    end
  end
`else
  // Plain round-robin selection
  always_comb begin
    pick_id  = rr_id;
    pick_vld = rr_vld;
  end
`endif

  // Start-wait timer: counts only in START and saturates at all-ones
  always_comb begin
    timer_d = timer_q;
    if (timer_q != {TW{1'b1}}) timer_d = timer_q + 1'b1;
  end

  assign timeout = (timer_q == TW'(START_TIMEOUT - 1));

  // Arbitration FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      req_ack_q    <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      arb_busy_q   <= 1'b0;
      tx_error_q   <= 1'b0;
      timer_q      <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      req_ack_q  <= '0;
      tx_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (!tx_busy && pick_vld) begin
            tx_data_q  <= req_data[pick_id*DATA_W +: DATA_W];
            req_ack_q  <= NUM_REQ'(1) << pick_id;
            grant_id_q <= pick_id;
            tx_start_q <= 1'b1;
            arb_busy_q <= 1'b1;
            state_q    <= ST_START;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
          end
        end
        ST_START: begin
          if (tx_busy) begin
            tx_start_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= ST_SEND;
          end else if (timeout) begin
            tx_start_q <= 1'b0;
            tx_error_q <= 1'b1;
            arb_busy_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= ST_IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            arb_busy_q <= 1'b0;
            state_q    <= ST_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
            if (req_lock[grant_id_q]) begin
              lock_q <= 1'b1;
            end else begin
              lock_q       <= 1'b0;
              last_grant_q <= grant_id_q;
            end
`else
            last_grant_q <= grant_id_q;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ack  = req_ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign arb_busy = arb_busy_q;
  assign tx_error = tx_error_q;

endmodule
